// File: rtl/mc_req_arb_pkg.sv
// Shared definitions for the memcache request arbiter.
//   MC_AW  default word-address width toward the cache
//   MC_DW  data width of the request/response port
//   MC_MW  byte-mask width; a set mask bit means the byte is NOT written.
//          The arbiter never interprets the mask, it only forwards it.
//   idx_w  width of an index into N requesters (at least one bit)
package mc_req_arb_pkg;

    localparam int unsigned MC_AW = 28;
    localparam int unsigned MC_DW = 32;
    localparam int unsigned MC_MW = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_rr_pick.sv
// Round-robin winner search.
//   req  in   N    request vector
//   ptr  in   IW   highest-priority position; must be below N
//   gnt  out  N    one-hot winner (all zero when no request)
//   idx  out  IW   winner index
//   any  out  1    at least one request present
module mc_rr_pick
    import mc_req_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        // Walk positions ptr, ptr+1, ... wrapping at N; first requester found wins.
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && req[i] && (i == cand)) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mc_req_arb.sv
// Round-robin arbiter sharing one memcache request/response port between N requesters.
// Presents each requester a plain valid/ack bus and drives the cache's early-address,
// req_valid and NAK-retry protocol. An optional lock keeps the current owner granted
// across back-to-back accesses.
//   clk, rst_n        clock, asynchronous active-low reset
//   u_valid/u_write/u_lock/u_addr/u_wdata/u_wmsk   per-requester request payload
//   u_ack, u_rdata    completion pulse to the granted requester, shared read data
//   req_addr_pre      cache address, one cycle ahead of req_valid
//   req_valid/req_write/req_wdata/req_wmsk          cache request
//   resp_ack/resp_nak/resp_rdata                    cache response
module mc_req_arb
    import mc_req_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = MC_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         u_valid,
    input  logic [N-1:0]         u_write,
    input  logic [N-1:0]         u_lock,
    input  logic [N*AW-1:0]      u_addr,
    input  logic [N*MC_DW-1:0]   u_wdata,
    input  logic [N*MC_MW-1:0]   u_wmsk,
    output logic [N-1:0]         u_ack,
    output logic [MC_DW-1:0]     u_rdata,
    output logic [AW-1:0]        req_addr_pre,
    output logic                 req_valid,
    output logic                 req_write,
    output logic [MC_DW-1:0]     req_wdata,
    output logic [MC_MW-1:0]     req_wmsk,
    input  logic                 resp_ack,
    input  logic                 resp_nak,
    input  logic [MC_DW-1:0]     resp_rdata
);

    localparam int unsigned IW = idx_w(N);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic           req_new_q, req_new_d;
    logic           lock_q, lock_d;
    logic [AW-1:0]  last_addr_q, last_addr_d;

    logic [N-1:0]   grant_oh;
    logic [N-1:0]   eligible;
    logic [N-1:0]   win_oh;
    logic [IW-1:0]  win_idx;
    logic           win_any;

    // Payload of the granted requester (g_*) and of the current IDLE winner (w_addr).
    logic [AW-1:0]    g_addr, w_addr;
    logic             g_write, g_lock, g_valid;
    logic [MC_DW-1:0] g_wdata;
    logic [MC_MW-1:0] g_wmsk;

    always_comb begin
        grant_oh = '0;
        g_addr   = '0;
        g_write  = 1'b0;
        g_lock   = 1'b0;
        g_valid  = 1'b0;
        g_wdata  = '0;
        g_wmsk   = '0;
        w_addr   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q == IW'(i)) begin
                grant_oh[i] = 1'b1;
                g_addr      = u_addr[AW*i +: AW];
                g_write     = u_write[i];
                g_lock      = u_lock[i];
                g_valid     = u_valid[i];
                g_wdata     = u_wdata[MC_DW*i +: MC_DW];
                g_wmsk      = u_wmsk[MC_MW*i +: MC_MW];
            end
            if (win_idx == IW'(i)) begin
                w_addr = u_addr[AW*i +: AW];
            end
        end
    end

    // While locked only the last owner may win; the others wait.
    assign eligible = lock_q ? (u_valid & grant_oh) : u_valid;

    mc_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (eligible),
        .ptr (rr_q),
        .gnt (win_oh),
        .idx (win_idx),
        .any (win_any)
    );

    // Outputs: combinational from state and the cache response.
    always_comb begin
        u_ack        = '0;
        u_rdata      = '0;
        req_addr_pre = last_addr_q;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_wdata    = '0;
        req_wmsk     = '0;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    req_addr_pre = w_addr;
                end
            end
            StBusy: begin
                req_addr_pre = g_addr;
                req_write    = g_write;
                req_wdata    = g_wdata;
                req_wmsk     = g_wmsk;
                // A NAK re-strobes in the same cycle; an ack overrides a concurrent NAK.
                req_valid    = req_new_q | (resp_nak & ~resp_ack);
                if (resp_ack) begin
                    u_ack   = grant_oh;
                    u_rdata = resp_rdata;
                end
            end
            default: ;
        endcase
    end

    // Next state.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        req_new_d   = 1'b0;
        lock_d      = lock_q;
        last_addr_d = last_addr_q;
        unique case (state_q)
            StIdle: begin
                if (lock_q && !g_valid && !g_lock) begin
                    lock_d = 1'b0;
                end
                if (win_any) begin
                    state_d     = StBusy;
                    grant_d     = win_idx;
                    req_new_d   = 1'b1;
                    last_addr_d = w_addr;
                end
            end
            StBusy: begin
                if (resp_ack) begin
                    state_d = StIdle;
                    rr_d    = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                    lock_d  = g_lock;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            req_new_q   <= 1'b0;
            lock_q      <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            req_new_q   <= req_new_d;
            lock_q      <= lock_d;
            last_addr_q <= last_addr_d;
        end
    end

endmodule
